// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, demux FSM states and the
// address-to-slot decode used by every window decoder.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_RESP} r_state_e;

  typedef struct packed {
    logic       mapped;
    logic [3:0] slot;
  } slot_dec_t;

  // Addresses below the base wrap to a huge index, so the lower bound is checked separately.
  function automatic slot_dec_t decode_slot(input logic [63:0] addr, input logic [63:0] base,
                                            input int unsigned slotBits,
                                            input int unsigned numSlots);
    slot_dec_t   res;
    logic [63:0] idx;
    idx        = (addr - base) >> slotBits;
    res.mapped = (addr >= base) && (idx < 64'(numSlots));
    res.slot   = idx[3:0];
    return res;
  endfunction

endpackage

// File: rtl/axil_demux_decode.sv
// Combinational window decoder: maps an AXI-Lite address onto one of the
// contiguous equal-size slave windows, or flags it as unmapped.
module axil_demux_decode
  import axil_pkg::*;
#(
  parameter int                    NUM_SLOTS       = 4,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    SLOT_ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  mapped_o,
  output logic [3:0]            slot_o
);

  slot_dec_t dec;

  always_comb begin
    dec      = decode_slot(64'(addr_i), 64'(BASE_ADDR), SLOT_ADDR_WIDTH, NUM_SLOTS);
    mapped_o = dec.mapped;
    slot_o   = dec.slot;
  end

endmodule

// File: rtl/axil_demux_1_n.sv
// AXI-Lite 1-to-N demultiplexer with independent single-outstanding read and
// write paths, DECERR for unmapped addresses and a saturating DECERR counter.
module axil_demux_1_n
  import axil_pkg::*;
#(
  parameter int                    NUM_SLOTS       = 4,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    SLOT_ADDR_WIDTH = 12,
  parameter logic [31:0]           DECERR_RDATA    = 32'hDEAD_BEEF
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [ADDR_WIDTH-1:0]                  s_awaddr_i,
  input  logic                                   s_awvalid_i,
  output logic                                   s_awready_o,
  input  logic [DATA_WIDTH-1:0]                  s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]                s_wstrb_i,
  input  logic                                   s_wvalid_i,
  output logic                                   s_wready_o,
  output logic [1:0]                             s_bresp_o,
  output logic                                   s_bvalid_o,
  input  logic                                   s_bready_i,
  input  logic [ADDR_WIDTH-1:0]                  s_araddr_i,
  input  logic                                   s_arvalid_i,
  output logic                                   s_arready_o,
  output logic [DATA_WIDTH-1:0]                  s_rdata_o,
  output logic [1:0]                             s_rresp_o,
  output logic                                   s_rvalid_o,
  input  logic                                   s_rready_i,
  output logic [NUM_SLOTS*ADDR_WIDTH-1:0]        m_awaddr_o,
  output logic [NUM_SLOTS-1:0]                   m_awvalid_o,
  input  logic [NUM_SLOTS-1:0]                   m_awready_i,
  output logic [NUM_SLOTS*DATA_WIDTH-1:0]        m_wdata_o,
  output logic [NUM_SLOTS*(DATA_WIDTH/8)-1:0]    m_wstrb_o,
  output logic [NUM_SLOTS-1:0]                   m_wvalid_o,
  input  logic [NUM_SLOTS-1:0]                   m_wready_i,
  input  logic [NUM_SLOTS*2-1:0]                 m_bresp_i,
  input  logic [NUM_SLOTS-1:0]                   m_bvalid_i,
  output logic [NUM_SLOTS-1:0]                   m_bready_o,
  output logic [NUM_SLOTS*ADDR_WIDTH-1:0]        m_araddr_o,
  output logic [NUM_SLOTS-1:0]                   m_arvalid_o,
  input  logic [NUM_SLOTS-1:0]                   m_arready_i,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0]        m_rdata_i,
  input  logic [NUM_SLOTS*2-1:0]                 m_rresp_i,
  input  logic [NUM_SLOTS-1:0]                   m_rvalid_i,
  output logic [NUM_SLOTS-1:0]                   m_rready_o,
  output logic [7:0]                             decerr_count_o
);

  localparam int                    STRB_WIDTH  = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] DECERR_DATA = DATA_WIDTH'(DECERR_RDATA);

  w_state_e                wState_q, wState_d;
  logic [ADDR_WIDTH-1:0]   awAddr_q, awAddr_d;
  logic                    awHeld_q, awHeld_d, wHeld_q, wHeld_d;
  logic [DATA_WIDTH-1:0]   wData_q, wData_d;
  logic [STRB_WIDTH-1:0]   wStrb_q, wStrb_d;
  logic                    awDone_q, awDone_d, wDone_q, wDone_d;
  logic [1:0]              bResp_q, bResp_d;
  logic                    bValid_q, bValid_d;

  r_state_e                rState_q, rState_d;
  logic [ADDR_WIDTH-1:0]   arAddr_q, arAddr_d;
  logic [DATA_WIDTH-1:0]   rData_q, rData_d;
  logic [1:0]              rResp_q, rResp_d;
  logic                    rValid_q, rValid_d;

  logic [7:0]              decerrCount_q, decerrCount_d;
  logic [8:0]              decerrSum;

  logic                    awMapped, arMapped;
  logic [3:0]              awSlot, arSlot;
  logic [NUM_SLOTS-1:0]    awSel, arSel;
  logic                    awHs, wHs, mAwHs, mWHs, mBHs, mArHs, mRHs;
  logic                    wDecerr, rDecerr;

  // Decoding the held addresses keeps every downstream strobe a function of registers only.
  axil_demux_decode #(
    .NUM_SLOTS(NUM_SLOTS), .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR(BASE_ADDR), .SLOT_ADDR_WIDTH(SLOT_ADDR_WIDTH)
  ) u_awDecode (.addr_i(awAddr_q), .mapped_o(awMapped), .slot_o(awSlot));

  axil_demux_decode #(
    .NUM_SLOTS(NUM_SLOTS), .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR(BASE_ADDR), .SLOT_ADDR_WIDTH(SLOT_ADDR_WIDTH)
  ) u_arDecode (.addr_i(arAddr_q), .mapped_o(arMapped), .slot_o(arSlot));

  assign awSel = NUM_SLOTS'(1) << awSlot;
  assign arSel = NUM_SLOTS'(1) << arSlot;

  assign s_awready_o = (wState_q == W_IDLE) && !awHeld_q;
  assign s_wready_o  = (wState_q == W_IDLE) && !wHeld_q;
  assign s_bresp_o   = bResp_q;
  assign s_bvalid_o  = bValid_q;
  assign s_arready_o = (rState_q == R_IDLE);
  assign s_rdata_o   = rData_q;
  assign s_rresp_o   = rResp_q;
  assign s_rvalid_o  = rValid_q;

  assign m_awaddr_o  = {NUM_SLOTS{awAddr_q}};
  assign m_wdata_o   = {NUM_SLOTS{wData_q}};
  assign m_wstrb_o   = {NUM_SLOTS{wStrb_q}};
  assign m_araddr_o  = {NUM_SLOTS{arAddr_q}};
  assign m_awvalid_o = (wState_q == W_ISSUE && awMapped && !awDone_q) ? awSel : '0;
  assign m_wvalid_o  = (wState_q == W_ISSUE && awMapped && !wDone_q)  ? awSel : '0;
  assign m_bready_o  = (wState_q == W_RESP && !bValid_q)              ? awSel : '0;
  assign m_arvalid_o = (rState_q == R_ISSUE && arMapped)              ? arSel : '0;
  assign m_rready_o  = (rState_q == R_RESP && !rValid_q)              ? arSel : '0;

  assign awHs  = s_awvalid_i && s_awready_o;
  assign wHs   = s_wvalid_i && s_wready_o;
  assign mAwHs = |(m_awvalid_o & m_awready_i);
  assign mWHs  = |(m_wvalid_o & m_wready_i);
  assign mBHs  = |(m_bready_o & m_bvalid_i);
  assign mArHs = |(m_arvalid_o & m_arready_i);
  assign mRHs  = |(m_rready_o & m_rvalid_i);

  assign wDecerr = (wState_q == W_ISSUE) && !awMapped;
  assign rDecerr = (rState_q == R_ISSUE) && !arMapped;

  assign decerrSum     = {1'b0, decerrCount_q} + {8'd0, wDecerr} + {8'd0, rDecerr};
  assign decerrCount_d = decerrSum[8] ? 8'hFF : decerrSum[7:0];
  assign decerr_count_o = decerrCount_q;

  // Write path: AW and W are collected independently, then issued to one slot.
  always_comb begin
    wState_d = wState_q;
    awAddr_d = awAddr_q;
    awHeld_d = awHeld_q;
    wData_d  = wData_q;
    wStrb_d  = wStrb_q;
    wHeld_d  = wHeld_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    bResp_d  = bResp_q;
    bValid_d = bValid_q;
    unique case (wState_q)
      W_IDLE: begin
        if (awHs) begin
          awAddr_d = s_awaddr_i;
          awHeld_d = 1'b1;
        end
        if (wHs) begin
          wData_d = s_wdata_i;
          wStrb_d = s_wstrb_i;
          wHeld_d = 1'b1;
        end
        if ((awHeld_q || awHs) && (wHeld_q || wHs)) begin
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          wState_d = W_ISSUE;
        end
      end
      W_ISSUE: begin
        if (!awMapped) begin
          bResp_d  = RESP_DECERR;
          bValid_d = 1'b1;
          wState_d = W_RESP;
        end else begin
          awDone_d = awDone_q || mAwHs;
          wDone_d  = wDone_q || mWHs;
          if (awDone_d && wDone_d) wState_d = W_RESP;
        end
      end
      W_RESP: begin
        if (mBHs) begin
          bResp_d  = m_bresp_i[awSlot*2 +: 2];
          bValid_d = 1'b1;
        end
        if (bValid_q && s_bready_i) begin
          bValid_d = 1'b0;
          awHeld_d = 1'b0;
          wHeld_d  = 1'b0;
          wState_d = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Read path: one address in flight, response registered before going upstream.
  always_comb begin
    rState_d = rState_q;
    arAddr_d = arAddr_q;
    rData_d  = rData_q;
    rResp_d  = rResp_q;
    rValid_d = rValid_q;
    unique case (rState_q)
      R_IDLE: begin
        if (s_arvalid_i) begin
          arAddr_d = s_araddr_i;
          rState_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (!arMapped) begin
          rResp_d  = RESP_DECERR;
          rData_d  = DECERR_DATA;
          rValid_d = 1'b1;
          rState_d = R_RESP;
        end else if (mArHs) begin
          rState_d = R_RESP;
        end
      end
      R_RESP: begin
        if (mRHs) begin
          rData_d  = m_rdata_i[arSlot*DATA_WIDTH +: DATA_WIDTH];
          rResp_d  = m_rresp_i[arSlot*2 +: 2];
          rValid_d = 1'b1;
        end
        if (rValid_q && s_rready_i) begin
          rValid_d = 1'b0;
          rState_d = R_IDLE;
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wState_q      <= W_IDLE;
      awAddr_q      <= '0;
      awHeld_q      <= 1'b0;
      wData_q       <= '0;
      wStrb_q       <= '0;
      wHeld_q       <= 1'b0;
      awDone_q      <= 1'b0;
      wDone_q       <= 1'b0;
      bResp_q       <= RESP_OKAY;
      bValid_q      <= 1'b0;
      rState_q      <= R_IDLE;
      arAddr_q      <= '0;
      rData_q       <= '0;
      rResp_q       <= RESP_OKAY;
      rValid_q      <= 1'b0;
      decerrCount_q <= '0;
    end else begin
      wState_q      <= wState_d;
      awAddr_q      <= awAddr_d;
      awHeld_q      <= awHeld_d;
      wData_q       <= wData_d;
      wStrb_q       <= wStrb_d;
      wHeld_q       <= wHeld_d;
      awDone_q      <= awDone_d;
      wDone_q       <= wDone_d;
      bResp_q       <= bResp_d;
      bValid_q      <= bValid_d;
      rState_q      <= rState_d;
      arAddr_q      <= arAddr_d;
      rData_q       <= rData_d;
      rResp_q       <= rResp_d;
      rValid_q      <= rValid_d;
      decerrCount_q <= decerrCount_d;
    end
  end

endmodule
